// File: rtl/manta_bus_pkg.sv
// Shared constants, types and address decode for the Manta multi-core bus router.
package manta_bus_pkg;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_RESP  = 2'd3;

    // Index width sized for the largest supported core count (16).
    localparam int CORE_IDX_W = $clog2(16);
    typedef logic [CORE_IDX_W-1:0] core_idx_t;

    localparam logic [15:0] ERR_DATA_DEFAULT = 16'hDEAD;

    // Full-width window number; callers compare it against NUM_CORES before truncating.
    function automatic logic [31:0] decode_core_idx(input logic [31:0] addr,
                                                    input int unsigned window_bits);
        return addr >> window_bits;
    endfunction

endpackage

// File: rtl/manta_bus_router_if.sv
// Bridge-side request/response and core-side broadcast bus of the Manta router.
interface manta_bus_router_if #(
    parameter int NUM_CORES  = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0]           req_addr_i;
    logic [DATA_WIDTH-1:0]           req_data_i;
    logic                            req_rw_i;
    logic                            req_valid_i;
    logic                            req_ready_o;
    logic [ADDR_WIDTH-1:0]           core_addr_o;
    logic [DATA_WIDTH-1:0]           core_wdata_o;
    logic                            core_rw_o;
    logic [NUM_CORES-1:0]            core_valid_o;
    logic [NUM_CORES*DATA_WIDTH-1:0] core_rdata_i;
    logic [NUM_CORES-1:0]            core_rvalid_i;
    logic [DATA_WIDTH-1:0]           res_data_o;
    logic                            res_valid_o;
    logic                            res_ready_i;
    logic                            res_err_o;
    logic [7:0]                      err_count_o;

    // Router side.
    modport slave (
        input  req_addr_i, req_data_i, req_rw_i, req_valid_i,
        output req_ready_o,
        output core_addr_o, core_wdata_o, core_rw_o, core_valid_o,
        input  core_rdata_i, core_rvalid_i,
        output res_data_o, res_valid_o, res_err_o, err_count_o,
        input  res_ready_i
    );

    // Bridge plus cores side.
    modport master (
        output req_addr_i, req_data_i, req_rw_i, req_valid_i,
        input  req_ready_o,
        input  core_addr_o, core_wdata_o, core_rw_o, core_valid_o,
        output core_rdata_i, core_rvalid_i,
        input  res_data_o, res_valid_o, res_err_o, err_count_o,
        output res_ready_i
    );
endinterface

// File: rtl/bus_watchdog.sv
// Response timeout counter: counts enabled cycles, flags when TIMEOUT_CYCLES-1 is reached.
module bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    assign expired = (count_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable && !expired) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end
endmodule

// File: rtl/manta_bus_router.sv
// Routes bridge requests to NUM_CORES debug-core windows and returns one response per read.
module manta_bus_router
    import manta_bus_pkg::*;
#(
    parameter int NUM_CORES      = 4,
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int WINDOW_BITS    = 12,
    parameter int TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(ERR_DATA_DEFAULT)
) (
    input logic               clk,
    input logic               rst_n,
    manta_bus_router_if.slave bus
);
    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
    logic                  rw_reg, rw_next;
    core_idx_t             idx_reg, idx_next;
    logic                  mapped_reg, mapped_next;
    logic [DATA_WIDTH-1:0] res_data_reg, res_data_next;
    logic                  res_err_reg, res_err_next;
    logic [7:0]            err_count_reg, err_count_next;
    logic                  err_inc;

    logic [31:0]           req_idx;
    logic                  req_mapped;
    logic [DATA_WIDTH-1:0] rdata_arr [NUM_CORES];
    logic [DATA_WIDTH-1:0] sel_rdata;
    logic                  sel_rvalid;
    logic                  wd_expired;

    assign req_idx    = decode_core_idx(32'(bus.req_addr_i), WINDOW_BITS);
    assign req_mapped = (req_idx < 32'(NUM_CORES));

    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
        assign rdata_arr[gi]        = bus.core_rdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
        assign bus.core_valid_o[gi] = (state_reg == ST_ISSUE) && mapped_reg
                                      && (idx_reg == core_idx_t'(gi));
    end

    // Only the addressed core's strobe is observed; all others are ignored.
    always_comb begin
        sel_rdata  = '0;
        sel_rvalid = 1'b0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (idx_reg == core_idx_t'(k)) begin
                sel_rdata  = rdata_arr[k];
                sel_rvalid = bus.core_rvalid_i[k];
            end
        end
    end

    bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_reg != ST_WAIT),
        .enable  (state_reg == ST_WAIT),
        .expired (wd_expired)
    );

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        rw_next       = rw_reg;
        idx_next      = idx_reg;
        mapped_next   = mapped_reg;
        res_data_next = res_data_reg;
        res_err_next  = res_err_reg;
        err_inc       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.req_valid_i) begin
                    addr_next   = bus.req_addr_i;
                    wdata_next  = bus.req_data_i;
                    rw_next     = bus.req_rw_i;
                    idx_next    = core_idx_t'(req_idx);
                    mapped_next = req_mapped;
                    state_next  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mapped_reg) begin
                    state_next = rw_reg ? ST_IDLE : ST_WAIT;
                end else begin
                    err_inc = 1'b1;
                    if (rw_reg) begin
                        state_next = ST_IDLE;
                    end else begin
                        res_data_next = ERR_DATA;
                        res_err_next  = 1'b1;
                        state_next    = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                // Data arriving on the timeout cycle still counts as a good response.
                if (sel_rvalid) begin
                    res_data_next = sel_rdata;
                    res_err_next  = 1'b0;
                    state_next    = ST_RESP;
                end else if (wd_expired) begin
                    res_data_next = ERR_DATA;
                    res_err_next  = 1'b1;
                    err_inc       = 1'b1;
                    state_next    = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.res_ready_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        err_count_next = (err_inc && (err_count_reg != 8'hFF)) ? err_count_reg + 8'd1
                                                               : err_count_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            rw_reg        <= 1'b0;
            idx_reg       <= '0;
            mapped_reg    <= 1'b0;
            res_data_reg  <= '0;
            res_err_reg   <= 1'b0;
            err_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            rw_reg        <= rw_next;
            idx_reg       <= idx_next;
            mapped_reg    <= mapped_next;
            res_data_reg  <= res_data_next;
            res_err_reg   <= res_err_next;
            err_count_reg <= err_count_next;
        end
    end

    // Broadcast fields stay at the last issued request; core_valid_o qualifies them.
    assign bus.req_ready_o  = (state_reg == ST_IDLE);
    assign bus.core_addr_o  = addr_reg;
    assign bus.core_wdata_o = wdata_reg;
    assign bus.core_rw_o    = rw_reg;
    assign bus.res_data_o   = res_data_reg;
    assign bus.res_valid_o  = (state_reg == ST_RESP);
    assign bus.res_err_o    = res_err_reg;
    assign bus.err_count_o  = err_count_reg;

endmodule

// File: doc/manta_bus_router.md
Name: manta_bus_router

Overview:
- Parametrised successor to the single-core Manta top-level bus path.
- Sits between bridge_rx/bridge_tx and NUM_CORES debug cores.
- Decodes each bridge request to one core address window and issues it as a one-cycle strobe.
- Collects the read response, enforces a response timeout, returns error data for unmapped or timed-out reads, and holds the response until bridge_tx accepts it.

Parameters:
- NUM_CORES, 4, number of core windows (1..16).
- ADDR_WIDTH, 16, bus address width.
- DATA_WIDTH, 16, bus data width.
- WINDOW_BITS, 12, low address bits per core window; core index = addr[ADDR_WIDTH-1:WINDOW_BITS].
- TIMEOUT_CYCLES, 255, maximum cycles to wait for core read data (>=2).
- ERR_DATA, 16'hDEAD, data returned for unmapped or timed-out reads.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_addr_i  in  ADDR_WIDTH  request address from bridge_rx
- req_data_i  in  DATA_WIDTH  write data
- req_rw_i  in  1  1 = write, 0 = read
- req_valid_i  in  1  request strobe
- req_ready_o  out  1  router can accept a request
- core_addr_o  out  ADDR_WIDTH  address broadcast to all cores
- core_wdata_o  out  DATA_WIDTH  write data broadcast
- core_rw_o  out  1  rw broadcast
- core_valid_o  out  NUM_CORES  one-hot request strobe
- core_rdata_i  in  NUM_CORES*DATA_WIDTH  packed read data; core k at [k*DATA_WIDTH +: DATA_WIDTH]
- core_rvalid_i  in  NUM_CORES  read-data strobes
- res_data_o  out  DATA_WIDTH  response to bridge_tx
- res_valid_o  out  1  response valid
- res_ready_i  in  1  bridge_tx accepts the response
- res_err_o  out  1  qualifies res_data_o as an error response
- err_count_o  out  8  saturating error counter

Behaviour:
- Reset (asynchronous, rst_n low). All outputs go to 0, except req_ready_o = 1. FSM goes to IDLE and the timeout counter clears.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i, register addr, data, rw and index, then go to ISSUE.
  - A request is dropped only if req_valid_i is asserted outside IDLE; bridge_rx ties ready high, so that is a protocol violation.
- ISSUE (exactly one cycle):
  - Mapped index (< NUM_CORES): core_valid_o[index] = 1 and core_addr/wdata/rw_o are driven from the registers. A write then returns to IDLE. A read goes to WAIT with the timeout counter = 0.
  - Unmapped index: no core strobe. A write returns to IDLE and increments err_count. A read goes to RESP with ERR_DATA, res_err_o = 1, and err_count increments.
- WAIT:
  - The counter increments each cycle.
  - core_rvalid_i[index] = 1 captures core_rdata_i[index] into the response register with err = 0, then goes to RESP.
  - Strobes from non-selected cores are ignored.
  - If the counter reaches TIMEOUT_CYCLES-1 without rvalid: go to RESP with ERR_DATA, err = 1, err_count++.
  - If rvalid and timeout occur in the same cycle, rvalid wins.
- RESP:
  - res_valid_o = 1 and res_data_o/res_err_o are held stable until res_ready_i.
  - On the handshake, go to IDLE and deassert res_valid_o in the next cycle.
  - rvalid strobes arriving here are ignored, including late data after a timeout.
- core_addr_o, core_wdata_o and core_rw_o hold their last value outside ISSUE; only core_valid_o qualifies them.
- Latency:
  - Request accepted in cycle 0; core strobe in cycle 1.
  - Read data with rvalid in cycle n gives res_valid_o in cycle n+1.
  - Minimum read turnaround is 3 cycles (rvalid in cycle 2).
- err_count_o saturates at 255 and clears only on reset.
- Reset mid-transaction aborts immediately; the pending response is discarded.

Decomposition:
- Package manta_bus_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - core_idx_t width constant ($clog2 of the maximum 16 cores)
  - ERR_DATA default
  - helper function decoding the index from an address
- Sub-module bus_watchdog:
  - timeout counter with clear/enable/expired
  - parametrised by TIMEOUT_CYCLES

Test Plan:
- Write to 16'h1004 with data 16'h00AB -> core_valid_o = 4'b0010 for exactly one cycle with addr 16'h1004, wdata 16'h00AB, rw = 1; no response; req_ready_o high again 2 cycles after accept.
- Read 16'h2010, core 2 returns 16'h1234 three cycles after its strobe -> res_valid_o with data 16'h1234, err 0; held for 5 cycles while res_ready_i = 0, released on the ready cycle.
- Read 16'h3000 with TIMEOUT_CYCLES = 8 and core 3 silent -> res_data_o = 16'hDEAD, res_err_o = 1, err_count = 1; core 3 rvalid 2 cycles later -> ignored, no second response.
- NUM_CORES = 3, read 16'h3000 -> no core strobe, immediate 16'hDEAD with err; write 16'h3000 -> no strobe, no response, err_count increments.
- Core 1 rvalid with 16'hFFFF during a read of core 0, then core 0 returns 16'h0042 -> response 16'h0042.
- Assert rst_n low during WAIT -> all outputs zero, req_ready_o = 1 on release; next read completes normally.
